emer_request_gen: RTL and testbench
===================================

// Module: emer_request_gen
// PURPOSE
//  Front end for the secondary-road emergency path: turns a raw, bouncy emergency input
//  (siren sensor or pushbutton) into the clean emer_signal request level for the
//  emergency controller. Holds the request until the controller acknowledges it and
//  watches the controller's state to detect service completion. Queues one extra press,
//  detects ack timeouts, and counts completed services.
// PARAMETERS
//  DEB_CYCLES   16   clk cycles the synced input must stay stable before it is accepted (>=2)
//  ACK_TIMEOUT  4'd8 tick_1hz strobes allowed in REQ with no ack before a fault
//  COOLDOWN_SEC 4'd5 tick_1hz strobes of lockout after each completed service
//  CNT_W        8    width of served_count
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  emer_raw      in   1      asynchronous raw emergency input, active high
//  tick_1hz      in   1      one-clk strobe per second from the shared timebase
//  ctrl_state    in   2      controller state: 00 = S0 red, 01 = S1 green, 10 = S2 yellow
//  emer_signal   out  1      request level to the controller
//  pending       out  1      a second press is queued
//  ack_fault     out  1      one-clk pulse when ACK_TIMEOUT expires
//  served_count  out  CNT_W  number of completed services; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - All state changes happen on posedge clk. reset=1 forces: emer_signal=0, pending=0,
//    ack_fault=0, served_count=0, FSM=IDLE, all counters=0, debounced level=0.
//  - Input path: 2-flop synchroniser, then debounce. The debounced level changes only
//    after DEB_CYCLES consecutive identical synced samples. A press is the rising edge of
//    the debounced level, which is a single-clk strobe.
//  - FSM IDLE:    on press -> REQ, and emer_signal=1 from the next cycle.
//  - FSM REQ:     the wait counter increments on each tick_1hz.
//                 ctrl_state==01 (ack) -> SERVICE; emer_signal=0 on the same clock edge.
//                 Wait counter reaches ACK_TIMEOUT -> pulse ack_fault, emer_signal=0,
//                 clear pending, -> IDLE.
//                 A press while in REQ is ignored.
//  - FSM SERVICE: wait for the ctrl_state transition 10 -> 00 (end of yellow).
//                 On it, served_count+1, then -> COOLDOWN, or -> IDLE when
//                 EMER_COOLDOWN_EN is not defined.
//                 A press while in SERVICE sets pending=1. This is one-deep; further
//                 presses are dropped.
//  - FSM COOLDOWN: count tick_1hz up to COOLDOWN_SEC, then -> IDLE.
//                 A press while in COOLDOWN sets pending.
//  - IDLE with pending=1: clear pending and -> REQ on the same cycle (no press needed).
//  - Simultaneous press and ack in REQ: the ack wins and the press is dropped.
//    Simultaneous tick and ack: the ack wins, no fault.
//  - ctrl_state==11 (illegal): treated as 00. Entering 00 without a preceding 10 does not
//    count as completion.
//  - Reset in mid-service aborts the request immediately. served_count is not incremented.
// CONFIGURATION
//  EMER_COOLDOWN_EN defined: COOLDOWN state exists and presses during it queue into pending.
//  EMER_COOLDOWN_EN undefined: SERVICE completion goes straight to IDLE, COOLDOWN_SEC is
//  unused, and pending is serviced immediately.
// STRUCTURE
//  - Shared package emer_pkg holds:
//    - controller state codes CTRL_S0/S1/S2 (2'b00/01/10)
//    - request FSM encodings ST_IDLE/ST_REQ/ST_SERVICE/ST_COOLDOWN (2 bits)
//  - Sub-module emer_debounce contains the synchroniser, the DEB_CYCLES stability counter
//    and the rising-edge strobe output. The FSM, timers and counter live in the top level.
// TESTING
//  1 Reset: hold reset 3 clk with emer_raw=1 -> all outputs 0. After release, one press is
//    seen after ~DEB_CYCLES+2 clk.
//  2 Bounce: emer_raw toggling every 3 clk for 40 clk, then held high -> exactly one
//    emer_signal assertion.
//  3 Full service: press; ctrl_state 00 -> 01 after 2 ticks; emer_signal drops on the ack
//    edge; 01 -> 10 -> 00 -> served_count=1. The next press is accepted only after 5 ticks.
//  4 Timeout: press with ctrl_state held at 00 -> ack_fault pulses once on the 8th tick,
//    emer_signal=0, FSM in IDLE.
//  5 Queue: two presses during SERVICE -> pending=1 and one queued request. After
//    completion plus cooldown, emer_signal re-asserts once and served_count ends at 2.
//  6 Macro off: repeat test 3 -> a press immediately after completion is accepted, and
//    served_count wraps 255 -> 0 when CNT_W=8.

Source files
------------

// File: rtl/emer_pkg.sv
// emer_pkg
//   Shared definitions for the secondary-road emergency request path.
//   - CTRL_S0/S1/S2 : state codes reported by the emergency controller
//   - req_state_e   : request FSM encodings used by emer_request_gen
//   - norm_ctrl     : folds the illegal controller code 2'b11 onto S0
package emer_pkg;

  localparam logic [1:0] CTRL_S0 = 2'b00;  // red
  localparam logic [1:0] CTRL_S1 = 2'b01;  // green (acts as the acknowledge)
  localparam logic [1:0] CTRL_S2 = 2'b10;  // yellow

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQ      = 2'b01,
    ST_SERVICE  = 2'b10,
    ST_COOLDOWN = 2'b11
  } req_state_e;

  // The controller should never report 2'b11; treat it as red so that a
  // glitch there cannot masquerade as yellow or as an acknowledge.
  function automatic logic [1:0] norm_ctrl(input logic [1:0] s);
    return (s == 2'b11) ? CTRL_S0 : s;
  endfunction

endpackage

// File: rtl/emer_request_gen_if.sv
// emer_request_gen_if
//   Request/acknowledge link between the emergency request generator and
//   the emergency controller.
//   - emer_signal : request level, driven by the generator
//   - ctrl_state  : controller state (00 red, 01 green, 10 yellow), driven
//                   by the controller; green doubles as the acknowledge
//   Modports: master = request generator, slave = controller.
interface emer_request_gen_if;

  logic       emer_signal;
  logic [1:0] ctrl_state;

  modport master (output emer_signal, input  ctrl_state);
  modport slave  (input  emer_signal, output ctrl_state);

endinterface

// File: rtl/emer_request_gen_debounce.sv
// emer_debounce
//   Two-flop synchroniser followed by a stability filter for the raw
//   emergency input. The filtered level only follows the synced input once
//   it has differed from the current level for DEB_CYCLES consecutive clocks.
//   Ports:
//   - clk, reset : system clock, synchronous active-high reset
//   - raw        : asynchronous raw input, active high
//   - press      : one-clk strobe on each rising edge of the filtered level
module emer_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive synced samples that disagree with level_q;
  // any agreeing sample restarts the count. The strobe is raised on the
  // same edge that the level rises, so it is exactly one clock wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      press  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press   <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/emer_request_gen.sv
// emer_request_gen
//   Front end of the secondary-road emergency path. Debounces the raw
//   emergency input, raises emer_signal until the controller acknowledges
//   (goes green), then watches for the yellow -> red transition that marks
//   the end of service. One extra press is queued, ack timeouts are
//   reported and completed services are counted.
//   Ports:
//   - clk, reset   : system clock, synchronous active-high reset
//   - emer_raw     : asynchronous raw emergency input
//   - tick_1hz     : one-clk strobe per second
//   - ctrl_if      : master side of emer_request_gen_if (emer_signal out,
//                    ctrl_state in)
//   - pending      : a second press is queued
//   - ack_fault    : one-clk pulse when the ack timeout expires
//   - served_count : completed services, wraps modulo 2^CNT_W
//   Build option: define EMER_COOLDOWN_EN to add a COOLDOWN_SEC-second
//   lockout after each service (presses during it are queued). Without it,
//   completion returns straight to IDLE.
module emer_request_gen
  import emer_pkg::*;
#(
  parameter int         DEB_CYCLES   = 16,
  parameter logic [3:0] ACK_TIMEOUT  = 4'd8,
  parameter logic [3:0] COOLDOWN_SEC = 4'd5,
  parameter int         CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 emer_raw,
  input  logic                 tick_1hz,
  emer_request_gen_if.master   ctrl_if,
  output logic                 pending,
  output logic                 ack_fault,
  output logic [CNT_W-1:0]     served_count
);

  logic       press;
  logic       emer_q;
  req_state_e state;
  logic [3:0] wait_cnt;
  logic [1:0] prev_ctrl;
  logic [1:0] ctrl_now;
  logic       completion;

`ifdef EMER_COOLDOWN_EN
  logic [3:0] cool_cnt;
`else
  logic       unused_cooldown_sec;
  assign unused_cooldown_sec = ^COOLDOWN_SEC;
`endif

  emer_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (emer_raw),
    .press (press)
  );

  assign ctrl_now            = norm_ctrl(ctrl_if.ctrl_state);
  assign completion          = (prev_ctrl == CTRL_S2) && (ctrl_now == CTRL_S0);
  assign ctrl_if.emer_signal = emer_q;

  // Request FSM. prev_ctrl remembers the previous (normalised) controller
  // state so that only a genuine yellow -> red step counts as completion.
  // In REQ the ack is tested before the tick, so a simultaneous tick can
  // never turn an acknowledged request into a fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      emer_q       <= 1'b0;
      pending      <= 1'b0;
      ack_fault    <= 1'b0;
      served_count <= '0;
      wait_cnt     <= '0;
      prev_ctrl    <= CTRL_S0;
`ifdef EMER_COOLDOWN_EN
      cool_cnt     <= '0;
`endif
    end else begin
      ack_fault <= 1'b0;
      prev_ctrl <= ctrl_now;
      case (state)
        ST_IDLE: begin
          if (pending || press) begin
            pending  <= 1'b0;
            state    <= ST_REQ;
            emer_q   <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (ctrl_now == CTRL_S1) begin
            state  <= ST_SERVICE;
            emer_q <= 1'b0;
          end else if (tick_1hz) begin
            if (wait_cnt + 4'd1 == ACK_TIMEOUT) begin
              ack_fault <= 1'b1;
              emer_q    <= 1'b0;
              pending   <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
        end
        ST_SERVICE: begin
          if (press) begin
            pending <= 1'b1;
          end
          if (completion) begin
            served_count <= served_count + 1'b1;
`ifdef EMER_COOLDOWN_EN
            state    <= ST_COOLDOWN;
            cool_cnt <= '0;
`else
            state    <= ST_IDLE;
`endif
          end
        end
`ifdef EMER_COOLDOWN_EN
        ST_COOLDOWN: begin
          if (press) begin
            pending <= 1'b1;
          end
          if (tick_1hz) begin
            if (cool_cnt + 4'd1 == COOLDOWN_SEC) begin
              state <= ST_IDLE;
            end else begin
              cool_cnt <= cool_cnt + 4'd1;
            end
          end
        end
`endif
        default: begin
          state  <= ST_IDLE;
          emer_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emer_request_gen.sv
// tb_emer_request_gen
//   Directed bench for emer_request_gen: reset, bounce rejection, full
//   service, ack timeout, press queueing, illegal controller codes with
//   simultaneous tick/ack, and served_count wrap. Expectations follow the
//   EMER_COOLDOWN_EN setting of the build.
module tb_emer_request_gen;
  import emer_pkg::*;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       emer_raw;
  logic       tick_1hz;
  logic       pending;
  logic       ack_fault;
  logic [7:0] served_count;

  int   checks   = 0;
  int   failures = 0;
  int   rises    = 0;
  logic prev_emer = 1'b0;

  emer_request_gen_if bus ();

  emer_request_gen #(
    .DEB_CYCLES   (DEB),
    .ACK_TIMEOUT  (4'd8),
    .COOLDOWN_SEC (4'd5),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .emer_raw     (emer_raw),
    .tick_1hz     (tick_1hz),
    .ctrl_if      (bus.master),
    .pending      (pending),
    .ack_fault    (ack_fault),
    .served_count (served_count)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one clock worth of inputs, then sample #1 after the edge.
  task automatic applyStimulus(input logic raw, input logic tick, input logic [1:0] ctrl);
    emer_raw       = raw;
    tick_1hz       = tick;
    bus.ctrl_state = ctrl;
    @(posedge clk);
    #1;
    if (bus.emer_signal && !prev_emer) rises++;
    prev_emer = bus.emer_signal;
    tick_1hz  = 1'b0;
  endtask

  task automatic hold(input int n, input logic raw, input logic [1:0] ctrl);
    for (int i = 0; i < n; i++) applyStimulus(raw, 1'b0, ctrl);
  endtask

  // One tick strobe followed by a quiet clock.
  task automatic ticks(input int n, input logic raw, input logic [1:0] ctrl);
    for (int i = 0; i < n; i++) begin
      applyStimulus(raw, 1'b1, ctrl);
      applyStimulus(raw, 1'b0, ctrl);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset(input logic raw);
    reset = 1'b1;
    hold(3, raw, CTRL_S0);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    emer_raw       = 1'b0;
    tick_1hz       = 1'b0;
    bus.ctrl_state = CTRL_S0;

    // Test 1: reset with input high, then first press latency
    doReset(1'b1);
    checkOutput("rst_emer", 32'(bus.emer_signal), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_fault", 32'(ack_fault), 32'd0);
    checkOutput("rst_count", 32'(served_count), 32'd0);
    hold(DEB + 2, 1'b1, CTRL_S0);
    checkOutput("press_lat_before", 32'(bus.emer_signal), 32'd0);
    applyStimulus(1'b1, 1'b0, CTRL_S0);
    checkOutput("press_lat_after", 32'(bus.emer_signal), 32'd1);

    // Test 2: bouncing input gives a single request
    doReset(1'b0);
    rises = 0;
    for (int i = 0; i < 40; i++) applyStimulus(((i / 3) % 2) == 0, 1'b0, CTRL_S0);
    checkOutput("bounce_quiet", 32'(bus.emer_signal), 32'd0);
    hold(DEB + 10, 1'b1, CTRL_S0);
    checkOutput("bounce_rises", 32'(rises), 32'd1);
    checkOutput("bounce_emer", 32'(bus.emer_signal), 32'd1);

    // Test 3: full service sequence
    doReset(1'b0);
    hold(DEB + 3, 1'b1, CTRL_S0);
    checkOutput("svc_req", 32'(bus.emer_signal), 32'd1);
    ticks(2, 1'b1, CTRL_S0);
    checkOutput("svc_wait", 32'(bus.emer_signal), 32'd1);
    applyStimulus(1'b1, 1'b0, CTRL_S1);
    checkOutput("svc_ack_drop", 32'(bus.emer_signal), 32'd0);
    applyStimulus(1'b1, 1'b0, CTRL_S1);
    applyStimulus(1'b1, 1'b0, CTRL_S2);
    checkOutput("svc_yellow_count", 32'(served_count), 32'd0);
    applyStimulus(1'b1, 1'b0, CTRL_S0);
    checkOutput("svc_done_count", 32'(served_count), 32'd1);
    hold(DEB + 4, 1'b0, CTRL_S0);
`ifdef EMER_COOLDOWN_EN
    hold(DEB + 4, 1'b1, CTRL_S0);
    checkOutput("cool_blocked", 32'(bus.emer_signal), 32'd0);
    checkOutput("cool_pending", 32'(pending), 32'd1);
    ticks(4, 1'b1, CTRL_S0);
    checkOutput("cool_4ticks", 32'(bus.emer_signal), 32'd0);
    applyStimulus(1'b1, 1'b1, CTRL_S0);
    checkOutput("cool_5th_tick", 32'(bus.emer_signal), 32'd0);
    applyStimulus(1'b1, 1'b0, CTRL_S0);
    checkOutput("cool_release", 32'(bus.emer_signal), 32'd1);
    checkOutput("cool_pend_clr", 32'(pending), 32'd0);
`else
    hold(DEB + 3, 1'b1, CTRL_S0);
    checkOutput("nocool_accept", 32'(bus.emer_signal), 32'd1);
`endif

    // Test 4: ack timeout
    doReset(1'b0);
    hold(DEB + 3, 1'b1, CTRL_S0);
    checkOutput("to_req", 32'(bus.emer_signal), 32'd1);
    ticks(7, 1'b1, CTRL_S0);
    checkOutput("to_7_fault", 32'(ack_fault), 32'd0);
    checkOutput("to_7_emer", 32'(bus.emer_signal), 32'd1);
    applyStimulus(1'b1, 1'b1, CTRL_S0);
    checkOutput("to_8_fault", 32'(ack_fault), 32'd1);
    checkOutput("to_8_emer", 32'(bus.emer_signal), 32'd0);
    checkOutput("to_8_idle", 32'(dut.state), 32'(ST_IDLE));
    applyStimulus(1'b1, 1'b0, CTRL_S0);
    checkOutput("to_pulse_end", 32'(ack_fault), 32'd0);

    // Test 5: two presses during service queue one request
    doReset(1'b0);
    hold(DEB + 3, 1'b1, CTRL_S0);
    hold(DEB + 4, 1'b0, CTRL_S0);
    applyStimulus(1'b0, 1'b0, CTRL_S1);
    checkOutput("q_ack", 32'(bus.emer_signal), 32'd0);
    hold(DEB + 4, 1'b1, CTRL_S1);
    checkOutput("q_pend1", 32'(pending), 32'd1);
    hold(DEB + 4, 1'b0, CTRL_S1);
    hold(DEB + 4, 1'b1, CTRL_S1);
    hold(DEB + 4, 1'b0, CTRL_S1);
    checkOutput("q_pend2", 32'(pending), 32'd1);
    rises = 0;
    applyStimulus(1'b0, 1'b0, CTRL_S2);
    applyStimulus(1'b0, 1'b0, CTRL_S0);
    checkOutput("q_count1", 32'(served_count), 32'd1);
`ifdef EMER_COOLDOWN_EN
    ticks(5, 1'b0, CTRL_S0);
`else
    applyStimulus(1'b0, 1'b0, CTRL_S0);
`endif
    checkOutput("q_reassert", 32'(bus.emer_signal), 32'd1);
    checkOutput("q_pend_clr", 32'(pending), 32'd0);
    applyStimulus(1'b0, 1'b0, CTRL_S1);
    applyStimulus(1'b0, 1'b0, CTRL_S2);
    applyStimulus(1'b0, 1'b0, CTRL_S0);
    checkOutput("q_count2", 32'(served_count), 32'd2);
`ifdef EMER_COOLDOWN_EN
    ticks(5, 1'b0, CTRL_S0);
`endif
    hold(3, 1'b0, CTRL_S0);
    checkOutput("q_rises", 32'(rises), 32'd1);
    checkOutput("q_final_emer", 32'(bus.emer_signal), 32'd0);

    // Test 7: tick+ack together, red without yellow, illegal 11 as red
    doReset(1'b0);
    hold(DEB + 3, 1'b1, CTRL_S0);
    ticks(7, 1'b1, CTRL_S0);
    applyStimulus(1'b1, 1'b1, CTRL_S1);
    checkOutput("tickack_fault", 32'(ack_fault), 32'd0);
    checkOutput("tickack_emer", 32'(bus.emer_signal), 32'd0);
    applyStimulus(1'b1, 1'b0, CTRL_S0);
    checkOutput("red_no_yellow", 32'(served_count), 32'd0);
    applyStimulus(1'b1, 1'b0, CTRL_S2);
    applyStimulus(1'b1, 1'b0, 2'b11);
    checkOutput("illegal_as_red", 32'(served_count), 32'd1);

    // Test 6: served_count wraps after 256 services
    doReset(1'b0);
    for (int s = 0; s < 256; s++) begin
      hold(DEB + 3, 1'b1, CTRL_S0);
      applyStimulus(1'b1, 1'b0, CTRL_S1);
      applyStimulus(1'b1, 1'b0, CTRL_S2);
      applyStimulus(1'b1, 1'b0, CTRL_S0);
`ifdef EMER_COOLDOWN_EN
      ticks(5, 1'b1, CTRL_S0);
`endif
      hold(DEB + 3, 1'b0, CTRL_S0);
      if (s == 254) checkOutput("wrap_255", 32'(served_count), 32'd255);
    end
    checkOutput("wrap_0", 32'(served_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
